// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Function : Boot-time writer for instruction memory. Takes a length-prefixed
//            byte stream over valid/ready and issues one write per word.
//            Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int PC_WIDTH          = 8,
  parameter int DEPTH             = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic                         wr_en,
  output logic [PC_WIDTH-1:0]          wr_addr,
  output logic [INSTRUCTION_WIDTH-1:0] wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int              BPW         = (INSTRUCTION_WIDTH + 7) / 8;
  localparam int              SW          = BPW * 8;
  localparam int              BCW         = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0]  c_LAST_BYTE = BCW'(BPW - 1);
  localparam logic [16:0]     c_DEPTH     = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                         state_q;
  logic [15:0]                    len_q;
  logic [15:0]                    word_q;
  logic [BCW-1:0]                 byte_q;
  logic [SW-1:0]                  shift_q;
  logic                           wr_en_q;
  logic [PC_WIDTH-1:0]            wr_addr_q;
  logic [INSTRUCTION_WIDTH-1:0]   wr_data_q;
  logic                           done_q;
  logic                           error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                     sum_q;
`endif

  logic                           w_accept;
  logic [SW-1:0]                  shift_d;
  logic [15:0]                    len_d;
  logic                           w_last_byte;
  logic                           w_last_word;

  // Big-endian assembly: older bytes move up, the newest lands in the low byte.
  assign shift_d     = SW'({shift_q, rx_data});
  assign len_d       = {len_q[15:8], rx_data};
  assign w_accept    = rx_valid && rx_ready;
  assign w_last_byte = (byte_q == c_LAST_BYTE);
  assign w_last_word = (word_q == len_q - 16'd1);

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                     rx_ready = 1'b1;
`endif
      default:                    rx_ready = 1'b0;
    endcase
  end

  // The loader is busy in exactly the states that take bytes.
  assign busy    = rx_ready;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign error   = error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      word_q    <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q <= S_LEN_HI;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            word_q  <= '0;
            byte_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            len_q[15:8] <= rx_data;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            len_q <= len_d;
            if (len_d == 16'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if ({1'b0, len_d} > c_DEPTH) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            shift_q <= shift_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_q + rx_data;
`endif
            if (w_last_byte) begin
              byte_q    <= '0;
              wr_en_q   <= 1'b1;
              wr_addr_q <= PC_WIDTH'(word_q);
              wr_data_q <= shift_d[INSTRUCTION_WIDTH-1:0];
              word_q    <= word_q + 16'd1;
              if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                state_q <= S_CSUM;
`else
                state_q <= S_DONE;
                done_q  <= 1'b1;
`endif
              end
            end else begin
              byte_q <= byte_q + BCW'(1);
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            if (rx_data == sum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory; the CPU fetch path is the reader.
- Accepts a byte stream over a valid/ready handshake, e.g. from the boot UART.
- Parses a 2-byte word-count header, assembles INSTRUCTION_WIDTH-bit words and issues one write per word into instruction memory, starting at address 0.
- Holds the CPU off (busy) until the program image is loaded.

Parameters:
INSTRUCTION_WIDTH, 16, width of one instruction word
PC_WIDTH, 8, instruction memory address width
DEPTH, 256, number of memory words; must be <= 2**PC_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse, begins a load
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
wr_en  output  1  one-cycle memory write strobe
wr_addr  output  PC_WIDTH  write address
wr_data  output  INSTRUCTION_WIDTH  write data
busy  output  1  load in progress
done  output  1  load completed successfully (sticky)
error  output  1  load aborted (sticky)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: all outputs 0; state IDLE; counters 0.
- BPW = ceil(INSTRUCTION_WIDTH/8) bytes per word.
- Byte transfer: a byte is accepted on a rising edge with rx_valid && rx_ready. rx_ready is combinational from state only: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 elsewhere.
- States:
  - IDLE: start -> LEN_HI, clears done/error. busy=0.
  - LEN_HI: accept byte -> N[15:8] -> LEN_LO.
  - LEN_LO: accept byte -> N[7:0].
    - N==0 -> DONE (no writes).
    - N>DEPTH -> ERROR.
    - Otherwise -> DATA.
  - DATA: bytes are big-endian within a word (first byte is most significant). The shift register is BPW*8 bits wide; wr_data takes its low INSTRUCTION_WIDTH bits, so excess high bits of the first byte are discarded.
    - On the edge accepting byte BPW of a word, register wr_en=1, wr_addr=word index, wr_data=assembled word. These are visible the next cycle for exactly one cycle.
    - wr_addr and wr_data hold their last values when wr_en=0.
    - Word index increments after each write. After word N-1 is accepted -> CSUM when LOADER_CHECKSUM_EN is defined, else DONE.
  - DONE: done=1, busy=0. start -> LEN_HI and clears done.
  - ERROR: error=1, busy=0, rx_ready=0. start -> LEN_HI and clears error.
- busy=1 in LEN_HI, LEN_LO, DATA and CSUM.
- Last word: done (or the CSUM state) and the final wr_en are visible in the same cycle.
- start while busy is ignored.
- N==DEPTH is legal; the last write goes to address DEPTH-1, with no wrap.
- Reset mid-load: the next cycle returns to IDLE with wr_en=0; any partial word is discarded. Memory contents already written are not touched.
- rx_valid may drop at any time between bytes. Stall length is unbounded; there is no timeout.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) covers all DATA bytes, excluding the header.
  - After the last word, state CSUM accepts one byte.
  - If the byte equals the sum -> DONE; otherwise -> ERROR.
  - Writes already issued are not undone.
  - For N==0 the CSUM state is skipped.
- Undefined: no CSUM state and no sum register; DATA goes directly to DONE.

Test Plan:
- Reset, then start, then bytes 00 02 12 34 AB CD with rx_valid held high -> wr_en pulses 2 times: (addr0, 0x1234), then (addr1, 0xABCD). done=1 in the same cycle as the second pulse. busy is 1 from the cycle after start until done.
- Header 00 00 -> DONE after LEN_LO with no wr_en; done=1, error=0.
- Header 01 01 (257 > DEPTH=256) -> error=1, rx_ready=0, no writes. A new start then reaches LEN_HI with error=0.
- Bytes 12 (gap of 5 idle cycles) 34 -> one write of 0x1234 to addr0, issued one cycle after byte 34 is accepted. rx_valid toggling does not corrupt data.
- Reset asserted after byte 12 of word 1 -> IDLE with wr_en=0. A fresh start, 00 01 55 66 -> a write of 0x5566 to addr0; no stale byte is used.
- LOADER_CHECKSUM_EN defined: 00 01 12 34 46 -> done. 00 01 12 34 47 -> error=1 after the write to addr0.
